alu_pipe: RTL and testbench

Parametrised, fully pipelined signed ALU with valid/ready handshakes on input and output, eight operations, status flags and backpressure. It is the successor to the single-stage four-op ALU. It sits between an operand-issue stage and a result consumer. Every operation has the same fixed latency, so results always leave in issue order.

---
 rtl/alu_pipe_pkg.sv | 34 +++
 rtl/alu_pipe_mul.sv | 34 +++
 rtl/alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined signed ALU: opcode encoding, status flags and helpers.
package alu_pipe_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_ERR  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'd0,
        OP_SUBAB = 3'd1,
        OP_SUBBA = 3'd2,
        OP_MULLO = 3'd3,
        OP_MULHI = 3'd4,
        OP_AND   = 3'd5,
        OP_OR    = 3'd6,
        OP_XOR   = 3'd7
    } op_e;

    typedef struct packed {
        logic err;
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

    function automatic logic is_mul(input op_e op);
        return (op == OP_MULLO) || (op == OP_MULHI);
    endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Signed DATAW x DATAW multiplier with STAGES register stages and a shared enable.
module alu_pipe_mul #(
    parameter int unsigned DATAW  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic                      clk,
    input  logic                      en_i,
    input  logic signed [DATAW-1:0]   a_i,
    input  logic signed [DATAW-1:0]   b_i,
    output logic signed [2*DATAW-1:0] p_o
);

    localparam int unsigned PW = 2 * DATAW;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] pipe_q [STAGES];

    assign a_ext = PW'(a_i);
    assign b_ext = PW'(b_i);

    // Product is formed at the first stage and then carried through the remaining ones.
    always_ff @(posedge clk) begin
        if (en_i) begin
            pipe_q[0] <= a_ext * b_ext;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign p_o = pipe_q[STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// Fully pipelined signed ALU, fixed latency MUL_STAGES+2, valid/ready on both sides.
// Optional build macro ALU_PIPE_SAT_EN: saturate ADD/SUBAB/SUBBA/MULLO instead of wrapping.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATAW      = 16,
    parameter int unsigned OPS        = 8,
    parameter int unsigned OPCODEW    = (OPS > 1) ? $clog2(OPS) : 1,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPCODEW-1:0] opcode,
    input  logic [DATAW-1:0]   dataa,
    input  logic [DATAW-1:0]   datab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATAW-1:0]   result,
    output logic [3:0]         flags
);

    localparam int unsigned WW = 2 * DATAW;
`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic stall_c;
    logic en_c;
    logic accept_c;

    // Stage 0: input register
    logic               v0_q;
    logic [OPCODEW-1:0] op0_q;
    logic [DATAW-1:0]   a0_q;
    logic [DATAW-1:0]   b0_q;

    op_e                op0_c;
    logic               err0_c;
    logic signed [WW-1:0] sa_c;
    logic signed [WW-1:0] sb_c;
    logic [WW-1:0]      raw0_c;

    // Stages 1..MUL_STAGES: non-mul results delayed alongside the multiplier
    logic               vd_q   [MUL_STAGES];
    op_e                opd_q  [MUL_STAGES];
    logic               errd_q [MUL_STAGES];
    logic [WW-1:0]      rawd_q [MUL_STAGES];
    logic signed [WW-1:0] prod_c;

    // Select stage: full-precision value of the beat, mul or not
    logic               vf_q;
    op_e                opf_q;
    logic               errf_q;
    logic [WW-1:0]      widef_q;

    // Output register
    logic               out_valid_q;
    logic [DATAW-1:0]   result_q;
    flags_t             flags_q;

    logic [DATAW:0]     hi_c;
    logic               fits_c;
    logic [DATAW-1:0]   res_d;
    flags_t             flags_d;

    assign stall_c  = out_valid_q && !out_ready;
    assign en_c     = !stall_c;
    assign in_ready = !stall_c && !rst;
    assign accept_c = in_valid && in_ready;

    assign sa_c = WW'($signed(a0_q));
    assign sb_c = WW'($signed(b0_q));

    // Full-precision add/sub and zero-extended logic results from stage 0
    always_comb begin
        op0_c  = op_e'(OP_W'(op0_q));
        err0_c = (32'(op0_q) >= OPS);
        raw0_c = '0;
        case (op0_c)
            OP_ADD:   raw0_c = sa_c + sb_c;
            OP_SUBAB: raw0_c = sa_c - sb_c;
            OP_SUBBA: raw0_c = sb_c - sa_c;
            OP_AND:   raw0_c = WW'(a0_q & b0_q);
            OP_OR:    raw0_c = WW'(a0_q | b0_q);
            OP_XOR:   raw0_c = WW'(a0_q ^ b0_q);
            default:  raw0_c = '0;
        endcase
    end

    alu_pipe_mul #(
        .DATAW  (DATAW),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk  (clk),
        .en_i (en_c),
        .a_i  (a0_q),
        .b_i  (b0_q),
        .p_o  (prod_c)
    );

    // The value fits in DATAW signed bits when its top DATAW+1 bits are all equal.
    assign hi_c   = widef_q[WW-1:DATAW-1];
    assign fits_c = (&hi_c) || !(|hi_c);

    always_comb begin
        res_d   = widef_q[DATAW-1:0];
        flags_d = '0;
        case (opf_q)
            OP_ADD, OP_SUBAB, OP_SUBBA, OP_MULLO: begin
                flags_d.ovf = !fits_c;
                if (SAT_EN && !fits_c) begin
                    res_d = widef_q[WW-1] ? {1'b1, {(DATAW-1){1'b0}}}
                                          : {1'b0, {(DATAW-1){1'b1}}};
                end
            end
            OP_MULHI: res_d = widef_q[WW-1:DATAW];
            default:  ;
        endcase
        if (errf_q) begin
            res_d        = '0;
            flags_d      = '0;
            flags_d.err  = 1'b1;
            flags_d.zero = 1'b1;
        end else begin
            flags_d.neg  = res_d[DATAW-1];
            flags_d.zero = (res_d == '0);
        end
    end

    // Every stage advances together unless the output is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            vf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                vd_q[i] <= 1'b0;
            end
        end else if (en_c) begin
            v0_q <= accept_c;
            if (accept_c) begin
                op0_q <= opcode;
                a0_q  <= dataa;
                b0_q  <= datab;
            end
            vd_q[0]   <= v0_q;
            opd_q[0]  <= op0_c;
            errd_q[0] <= err0_c;
            rawd_q[0] <= raw0_c;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                vd_q[i]   <= vd_q[i-1];
                opd_q[i]  <= opd_q[i-1];
                errd_q[i] <= errd_q[i-1];
                rawd_q[i] <= rawd_q[i-1];
            end
            vf_q    <= vd_q[MUL_STAGES-1];
            opf_q   <= opd_q[MUL_STAGES-1];
            errf_q  <= errd_q[MUL_STAGES-1];
            widef_q <= is_mul(opd_q[MUL_STAGES-1]) ? prod_c : rawd_q[MUL_STAGES-1];
            out_valid_q <= vf_q;
            if (vf_q) begin
                result_q <= res_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized self-checking bench for alu_pipe against an arithmetic reference model.
// Two instances share stimulus: OPS=8 and OPS=6 (opcodes 6 and 7 illegal on the second).
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned MS  = 2;
    localparam int unsigned LAT = MS + 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [2:0]    opcode    = '0;
    logic [DW-1:0] dataa     = '0;
    logic [DW-1:0] datab     = '0;

    logic          in_ready, in_ready6;
    logic          out_valid, out_valid6;
    logic [DW-1:0] result, result6;
    logic [3:0]    flags, flags6;

    always #5 clk = ~clk;

    alu_pipe #(.DATAW(DW), .OPS(8), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    alu_pipe #(.DATAW(DW), .OPS(6), .MUL_STAGES(MS)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .opcode(opcode), .dataa(dataa), .datab(datab),
        .out_valid(out_valid6), .out_ready(out_ready), .result(result6), .flags(flags6)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: {result, err, ovf, neg, zero} from plain signed integer arithmetic.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input int ops);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint full = 0;
        logic [15:0] r = '0;
        logic ovf = 1'b0;
        if (int'(op) >= ops) return {16'h0000, 4'b1001};
        case (op)
            3'd0: full = sa + sb;
            3'd1: full = sa - sb;
            3'd2: full = sb - sa;
            3'd3: full = sa * sb;
            3'd4: full = (sa * sb) >>> 16;
            3'd5: full = longint'(a & b);
            3'd6: full = longint'(a | b);
            default: full = longint'(a ^ b);
        endcase
        r = 16'(full);
        if (op <= 3'd3) begin
            ovf = (full > 32767) || (full < -32768);
`ifdef ALU_PIPE_SAT_EN
            if (ovf) r = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
        end
        return {r, 1'b0, ovf, r[15], (r == 16'h0000)};
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          acc_cyc;
        int          acc_stalls;
    } beat_t;

    beat_t       q[$];
    beat_t       mon_b;
    bit          mon_en     = 1'b0;
    int          stall_cnt  = 0;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_out   = '0;

    // Scoreboard: order, values, fixed latency plus stall cycles, and output hold under stall.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready) && !rst));
            if (prev_stall) check("hold_under_stall", 32'({result, flags}), 32'(prev_out));
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out", 32'(out_valid), 32'd0);
                    end else begin
                        mon_b = q.pop_front();
                        check("result_ops8", 32'({result, flags}), 32'(model(mon_b.op, mon_b.a, mon_b.b, 8)));
                        check("result_ops6", 32'({result6, flags6}), 32'(model(mon_b.op, mon_b.a, mon_b.b, 6)));
                        check("latency", 32'(cyc),
                              32'(mon_b.acc_cyc + 1 + int'(LAT) + (stall_cnt - mon_b.acc_stalls)));
                    end
                end
                if (in_valid && in_ready) q.push_back('{opcode, dataa, datab, cyc, stall_cnt});
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_out   = {result, flags};
            if (prev_stall) stall_cnt++;
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = 3-cycle stall at first out_valid
    int rmode      = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (!stall_done && out_valid) begin
                        stall_left = 3;
                        stall_done = 1'b1;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        in_valid = 1'b1;
        opcode   = op;
        dataa    = a;
        datab    = b;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int guard = 0;
        in_valid = 1'b0;
        while (q.size() > 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        idle(2);
    endtask

    function automatic logic [15:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back basic ops
        send(3'd0, 16'h0003, 16'h0005);
        send(3'd2, 16'h0005, 16'h0003);
        send(3'd5, 16'hF0F0, 16'h0FF0);
        drain();

        // Overflow, multiply corners, and opcodes illegal on the OPS=6 instance
        send(3'd0, 16'h7FFF, 16'h0001);
        send(3'd1, 16'h8000, 16'h0001);
        send(3'd2, 16'h7FFF, 16'h8000);
        send(3'd3, 16'hFFFD, 16'h0005);
        send(3'd4, 16'hFFFD, 16'h0005);
        send(3'd3, 16'h0100, 16'h0100);
        send(3'd3, 16'h8000, 16'h8000);
        send(3'd4, 16'h8000, 16'h8000);
        send(3'd6, 16'h1234, 16'h5678);
        send(3'd7, 16'hA5A5, 16'hFFFF);
        drain();

        // Backpressure: six beats every cycle, 3-cycle stall at first result
        rmode      = 2;
        stall_done = 1'b0;
        for (int i = 0; i < 6; i++) send(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
        drain();
        rmode = 0;

        // Random traffic with random gaps and random out_ready
        rmode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
        end
        drain();
        rmode = 0;
        idle(2);

        // Reset with three beats in flight: nothing may come out
        send(3'd0, 16'h0001, 16'h0001);
        send(3'd3, 16'h0002, 16'h0003);
        send(3'd7, 16'h00FF, 16'h0F0F);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_midrst", 32'(in_ready), 32'd1);
        repeat (LAT + 4) begin
            @(negedge clk);
            check("flushed_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(3'd1, 16'h0010, 16'h0004);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
